// File: rtl/req_ack_pkg.sv
// Shared FSM state type and default parameter values for the req/ack responder.
package req_ack_pkg;

  localparam int DEF_DATA_W         = 8;
  localparam int DEF_DEPTH          = 4;
  localparam int DEF_SERVICE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    SERVICE    = 2'd2,
    ACK_HI     = 2'd3
  } responder_state_t;

endpackage

// File: rtl/req_ack_fifo.sv
// Power-of-two circular FIFO with occupancy count; storage is not reset, only
// pointers and count are.
module req_ack_fifo
  import req_ack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rptr];

  // A pop that frees a slot on the same edge lets a push land even at full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/req_ack_responder.sv
// 4-phase req/ack responder: captures a payload, services it for a fixed number
// of cycles, then pushes it into an output FIFO and raises ack.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int SERVICE_CYCLES = DEF_SERVICE_CYCLES
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     ack,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     proto_err
);

  localparam int CNT_W = $clog2(SERVICE_CYCLES + 1);

  responder_state_t  state;
  responder_state_t  state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hold;
  logic              capture;
  logic              push;
  logic              pop;
  logic              violation;
  logic              full;
  logic              empty;

  // Only this FSM pushes and only one transaction is in flight, so space seen
  // free at capture is still free when the push happens.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    push      = 1'b0;
    violation = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!full) begin
            capture   = 1'b1;
            state_nxt = SERVICE;
          end else begin
            state_nxt = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (!req) begin
          violation = 1'b1;
          state_nxt = IDLE;
        end else if (!full) begin
          capture   = 1'b1;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (!req) begin
          violation = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          push      = 1'b1;
          state_nxt = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      ack       <= (state_nxt == ACK_HI);
      proto_err <= violation;
      if (capture) begin
        cnt <= CNT_W'(SERVICE_CYCLES);
      end else if (state == SERVICE) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      hold <= req_data;
    end
  end

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  req_ack_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (hold),
    .pop       (pop),
    .pop_data  (out_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_req_ack_responder.sv
// Scoreboard bench for req_ack_responder: an initiator issues handshakes and
// queues expected payloads; a monitor pops and compares on every FIFO pop.
module tb_req_ack_responder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SC     = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk       = 1'b0;
  logic              rstn      = 1'b1;
  logic              req       = 1'b0;
  logic [DATA_W-1:0] req_data  = '0;
  logic              out_ready = 1'b0;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     fifo_count;
  logic              proto_err;

  int total     = 0;
  int bad       = 0;
  int acked     = 0;
  int popped    = 0;
  int perr_seen = 0;
  int perr_exp  = 0;
  bit ready_rand = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  req_ack_responder #(
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .SERVICE_CYCLES (SC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens on the next edge whenever valid and ready are high here.
  always @(negedge clk) begin
    if (rstn) begin
      if (proto_err) perr_seen++;
      if (out_valid && out_ready) begin
        check_output("pop has expected entry", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          check_output("pop data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        popped++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_rand) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_reset();
    rstn = 1'b0;
    #1;
    check_output("reset ack", 32'(ack), 0);
    check_output("reset fifo_count", 32'(fifo_count), 0);
    check_output("reset out_valid", 32'(out_valid), 0);
    check_output("reset proto_err", 32'(proto_err), 0);
    exp_q.delete();
    acked  = 0;
    popped = 0;
    tick();
    tick();
  endtask

  // Raise req and expect ack exactly SC edges after the edge that finds space.
  task automatic apply_stimulus(input logic [DATA_W-1:0] d, input bit pop_on_push);
    int waited = 0;
    req_data = d;
    req      = 1'b1;
    exp_q.push_back(d);
    while ((acked - popped) >= DEPTH && waited < 200) begin
      tick();
      waited++;
      check_output("ack low while waiting", 32'(ack), 0);
      check_output("count while waiting", 32'(fifo_count), acked - popped);
    end
    if (waited >= 200) check_output("wait for space bound", waited, 0);
    for (int i = 1; i <= SC + 1; i++) begin
      if (pop_on_push && i == SC + 1) out_ready = 1'b1;
      tick();
      if (pop_on_push && i == SC + 1) out_ready = 1'b0;
      if (i <= SC) begin
        check_output("ack low in service", 32'(ack), 0);
        check_output("count in service", 32'(fifo_count), acked - popped);
      end
    end
    acked++;
    check_output("ack rise", 32'(ack), 1);
    check_output("count after push", 32'(fifo_count), acked - popped);
  endtask

  task automatic end_txn(input int hold_cycles);
    repeat (hold_cycles) begin
      tick();
      check_output("ack held", 32'(ack), 1);
    end
    req = 1'b0;
    tick();
    check_output("ack fall", 32'(ack), 0);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check_output("drain fifo_count", 32'(fifo_count), 0);
    check_output("drain queue", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    #2;
    apply_reset();
    rstn = 1'b1;

    // Basic handshake
    apply_stimulus(8'hA5, 1'b0);
    check_output("s1 out_valid", 32'(out_valid), 1);
    check_output("s1 out_data", 32'(out_data), 32'h A5);
    end_txn(0);

    // Early withdrawal in SERVICE
    req_data = 8'h3C;
    req      = 1'b1;
    tick();
    req = 1'b0;
    tick();
    perr_exp++;
    check_output("s3 proto_err pulse", 32'(proto_err), 1);
    check_output("s3 ack", 32'(ack), 0);
    tick();
    check_output("s3 proto_err clear", 32'(proto_err), 0);
    check_output("s3 fifo_count", 32'(fifo_count), acked - popped);

    // Full FIFO: fifth request waits for a single pop
    drain();
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(DATA_W'(8'h10 + i), 1'b0);
      end_txn(0);
    end
    check_output("s2 full count", 32'(fifo_count), DEPTH);
    fork
      begin
        apply_stimulus(8'h14, 1'b0);
        end_txn(1);
      end
      begin
        repeat (6) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    join
    check_output("s2 refilled count", 32'(fifo_count), DEPTH);

    // Withdrawal while waiting for space
    req_data = 8'hEE;
    req      = 1'b1;
    tick();
    check_output("s2 wait ack", 32'(ack), 0);
    req = 1'b0;
    tick();
    perr_exp++;
    check_output("wait withdraw proto_err", 32'(proto_err), 1);
    tick();
    check_output("wait withdraw count", 32'(fifo_count), DEPTH);

    // Simultaneous push and pop at DEPTH-1
    drain();
    for (int i = 0; i < DEPTH - 1; i++) begin
      apply_stimulus(DATA_W'(8'h20 + i), 1'b0);
      end_txn(0);
    end
    apply_stimulus(8'h23, 1'b1);
    check_output("s4 count unchanged", 32'(fifo_count), DEPTH - 1);
    end_txn(0);
    drain();

    // Reset mid-SERVICE with req dropped during reset
    apply_stimulus(8'h40, 1'b0);
    end_txn(0);
    req_data = 8'h5A;
    req      = 1'b1;
    tick();
    tick();
    apply_reset();
    req = 1'b0;
    rstn = 1'b1;
    repeat (3) tick();
    check_output("s5 no entry count", 32'(fifo_count), 0);
    check_output("s5 no entry valid", 32'(out_valid), 0);
    check_output("s5 ack", 32'(ack), 0);

    // Reset mid-SERVICE with req held: restart from IDLE after release
    req_data = 8'h77;
    req      = 1'b1;
    tick();
    apply_reset();
    rstn = 1'b1;
    apply_stimulus(8'h77, 1'b0);
    end_txn(0);
    drain();

    // Wrap-around: ten in-order transactions with consumer always ready
    base      = popped;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(DATA_W'(i), 1'b0);
      end_txn(0);
    end
    drain();
    check_output("s6 pop total", popped - base, 10);

    // Randomised handshakes against a random consumer
    ready_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int gap;
      apply_stimulus(DATA_W'($urandom), 1'b0);
      end_txn($urandom_range(0, 2));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        tick();
        check_output("idle ack", 32'(ack), 0);
      end
    end
    ready_rand = 1'b0;
    tick();
    drain();

    check_output("proto_err pulses", perr_seen, perr_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_ack_responder.md
REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

Interface
REQ-001: Parameter DATA_W, default 8, shall set the payload width in bits.
REQ-002: Parameter DEPTH, default 4, shall set the output FIFO depth; it shall be a power of 2 and at least 2.
REQ-003: Parameter SERVICE_CYCLES, default 2, shall set the cycles between request capture and ack rise; it shall be at least 1.
REQ-004: clk  input  1  shall be the single clock; all state shall update on its rising edge.
REQ-005: rstn  input  1  shall be the asynchronous, active-low reset.
REQ-006: req  input  1  shall be the 4-phase request from the external initiator.
REQ-007: req_data  input  DATA_W  shall be the payload, stable while req is high.
REQ-008: ack  output  1  shall be the 4-phase acknowledge, driven from a flop.
REQ-009: out_valid  output  1  shall be high when the FIFO is non-empty.
REQ-010: out_data  output  DATA_W  shall be the FIFO head entry, valid when out_valid is high.
REQ-011: out_ready  input  1  shall be the downstream consumer ready signal.
REQ-012: fifo_count  output  $clog2(DEPTH)+1  shall be the current FIFO occupancy.
REQ-013: proto_err  output  1  shall pulse high for one cycle on a protocol violation.

Function
REQ-014: The FSM shall have exactly these states: IDLE, WAIT_SPACE, SERVICE and ACK_HI.
REQ-015: In IDLE, req=1 with fifo_count<DEPTH shall capture req_data into a hold register, load the down-counter with SERVICE_CYCLES and go to SERVICE.
REQ-016: In IDLE, req=1 with the FIFO full shall go to WAIT_SPACE with no capture.
REQ-017: In WAIT_SPACE, once fifo_count<DEPTH with req still high, the block shall capture, load the counter and go to SERVICE.
REQ-018: In SERVICE, the counter shall decrement each cycle.
REQ-019: In SERVICE, on the edge where the counter equals 1, the hold register shall be pushed to the FIFO and the FSM shall go to ACK_HI.
REQ-020: ack shall be 1 only in ACK_HI and shall rise exactly SERVICE_CYCLES edges after the capture edge, on the same edge that out_valid reflects the push.
REQ-021: In ACK_HI, req sampled 0 shall return the FSM to IDLE, with ack low the next cycle; req held 1 shall keep ACK_HI.
REQ-022: req sampled 0 in WAIT_SPACE or SERVICE shall be a protocol violation.
REQ-023: On a protocol violation the block shall pulse proto_err for one cycle, discard the hold register with no push, and go to IDLE.
REQ-024: The FIFO shall pop when out_valid=1 and out_ready=1.
REQ-025: A simultaneous push and pop shall leave fifo_count unchanged, including at DEPTH-1 and at full.
REQ-026: FIFO read and write pointers shall wrap modulo DEPTH.
REQ-027: fifo_count shall never exceed DEPTH.
REQ-028: A pop from an empty FIFO shall be impossible by construction.
REQ-029: Space checked at capture shall stay reserved, because this FSM is the only pusher and at most one transaction is in flight.
REQ-030: A new req rise shall be accepted on the first IDLE cycle after ack falls.

Reset
REQ-031: rstn low shall asynchronously force FSM=IDLE, ack=0, proto_err=0, counter=0, pointers=0, fifo_count=0 and out_valid=0.
REQ-032: out_data contents and the hold register need not be reset.
REQ-033: A reset asserted mid-transaction shall abandon that transaction with no push.
REQ-034: After reset release, the block shall sample req fresh; if req is still high, it shall start a new transaction from IDLE.

Structure
REQ-035: Package req_ack_pkg shall hold the responder state enum (responder_state_t) and the default parameter constants.
REQ-036: The FIFO shall be a sub-module req_ack_fifo, parameterised by DATA_W and DEPTH, with push/pop/count/full/empty ports.
REQ-037: The FSM and the counter shall live in req_ack_responder.

Verification
REQ-038: Scenario 1 -- basic handshake: after reset, req=1 with req_data=0xA5 at edge 0 -> ack=1 and out_valid=1 with out_data=0xA5 after edge 2; req=0 -> ack=0 the next cycle.
REQ-039: Scenario 2 -- full FIFO: with out_ready=0, five back-to-back handshakes -> fifo_count=4 and the FSM in WAIT_SPACE with ack=0 on the fifth; one pop -> capture, then ack after 2 more edges, fifo_count=4.
REQ-040: Scenario 3 -- early withdrawal: req drops one cycle after capture -> proto_err pulses once, fifo_count unchanged, ack stays 0.
REQ-041: Scenario 4 -- simultaneous push and pop: fifo_count=3, out_ready=1 on the push edge -> fifo_count stays 3 and data order is preserved.
REQ-042: Scenario 5 -- reset mid-SERVICE: rstn pulsed low -> ack=0 and fifo_count=0 immediately, and no entry appears after release.
REQ-043: Scenario 6 -- wrap-around: 10 transactions with out_ready=1 -> outputs in exact order 0x00..0x09 with pointers wrapped twice.
